// File: rtl/vga_pattern_gen_if.sv
// Pin bundle between the VGA pattern generator and the board connector.
// The generator drives sync, colour and frame_tick, and reads the pattern request.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 4
);
  logic [2:0]         mode;
  logic               horizSyncOut;
  logic               vertSyncOut;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               frame_tick;

  modport master (
    input  mode,
    output horizSyncOut, vertSyncOut, VGA_R, VGA_G, VGA_B, frame_tick
  );

  modport slave (
    output mode,
    input  horizSyncOut, vertSyncOut, VGA_R, VGA_G, VGA_B, frame_tick
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator with a phase-accumulator pixel strobe.
// Pattern selection is latched only at frame boundaries so a frame never mixes two patterns.
module vga_pattern_gen #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          COLOR_W    = 4,
  parameter logic [15:0] STROBE_INC = 16'h4000,
  parameter int          BOX_SIZE   = 32
) (
  input logic         CLK100MHZ,
  input logic         reset,
  vga_pattern_gen_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [COLOR_W-1:0] FULL = '1;

  logic [15:0]        acc_q, acc_d;
  logic               strobe;
  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic [2:0]         act_mode_q, act_mode_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [HW-1:0]      box_x_q, box_x_d, next_x;
  logic [VW-1:0]      box_y_q, box_y_d, next_y;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               frame_tick_q, frame_tick_d;
  logic               fb;

  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
  logic               hsync_n, vsync_n;
  logic [2:0]         bar;
  int                 h, v, bx, by;

  // Colour-bar sequence: white, yellow, cyan, green, magenta, red, blue, black as {R,G,B}.
  function automatic logic [2:0] bar_mask(input int x);
    case (x / BAR_W)
      0:       bar_mask = 3'b111;
      1:       bar_mask = 3'b110;
      2:       bar_mask = 3'b011;
      3:       bar_mask = 3'b010;
      4:       bar_mask = 3'b101;
      5:       bar_mask = 3'b100;
      6:       bar_mask = 3'b001;
      default: bar_mask = 3'b000;
    endcase
  endfunction

  always_comb begin
    {strobe, acc_d} = {1'b0, acc_q} + {1'b0, STROBE_INC};
  end

  // Pixel value and sync levels for the current, not-yet-advanced counter position.
  always_comb begin
    h       = int'(h_cnt_q);
    v       = int'(v_cnt_q);
    bx      = int'(box_x_q);
    by      = int'(box_y_q);
    pix_r   = '0;
    pix_g   = '0;
    pix_b   = '0;
    bar     = 3'b000;
    hsync_n = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    vsync_n = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    if ((h < H_ACTIVE) && (v < V_ACTIVE)) begin
      case (act_mode_q)
        3'd1: pix_r = FULL;
        3'd2: bar = bar_mask(h);
        3'd3: begin
          if ((((h ^ v) >> 5) & 1) == 1) bar = 3'b111;
        end
        3'd4: begin
          pix_r = COLOR_W'((h << COLOR_W) / H_ACTIVE);
          pix_g = COLOR_W'((h << COLOR_W) / H_ACTIVE);
          pix_b = COLOR_W'((h << COLOR_W) / H_ACTIVE);
        end
        3'd5: bar = bar_mask((h + int'(frame_cnt_q)) % H_ACTIVE);
        3'd6: begin
          if ((h >= bx) && (h < bx + BOX_SIZE) && (v >= by) && (v < by + BOX_SIZE))
            pix_g = FULL;
          else
            pix_b = FULL;
        end
        3'd7: begin
          if ((h == 0) || (h == H_ACTIVE - 1) || (v == 0) || (v == V_ACTIVE - 1))
            bar = 3'b111;
        end
        default: bar = 3'b000;
      endcase
      if (bar[2]) pix_r = FULL;
      if (bar[1]) pix_g = FULL;
      if (bar[0]) pix_b = FULL;
    end
  end

  // Counter advance, output pipeline and once-per-frame updates (mode latch, scroll, box).
  always_comb begin
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    act_mode_d   = act_mode_q;
    frame_cnt_d  = frame_cnt_q;
    box_x_d      = box_x_q;
    box_y_d      = box_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    frame_tick_d = 1'b0;
    next_x       = dir_x_q ? box_x_q + 1'b1 : box_x_q - 1'b1;
    next_y       = dir_y_q ? box_y_q + 1'b1 : box_y_q - 1'b1;
    fb           = strobe && (h == H_TOT - 1) && (v == V_TOT - 1);

    if (strobe) begin
      hsync_d = hsync_n;
      vsync_d = vsync_n;
      r_d     = pix_r;
      g_d     = pix_g;
      b_d     = pix_b;
      if (h == H_TOT - 1) begin
        h_cnt_d = '0;
        v_cnt_d = (v == V_TOT - 1) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    if (fb) begin
      act_mode_d   = vga.mode;
      frame_cnt_d  = frame_cnt_q + 8'd1;
      frame_tick_d = 1'b1;
      box_x_d      = next_x;
      box_y_d      = next_y;
      if ((next_x == '0) || (int'(next_x) == H_ACTIVE - BOX_SIZE)) dir_x_d = !dir_x_q;
      if ((next_y == '0) || (int'(next_y) == V_ACTIVE - BOX_SIZE)) dir_y_d = !dir_y_q;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      acc_q        <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      act_mode_q   <= 3'd0;
      frame_cnt_q  <= 8'd0;
      box_x_q      <= '0;
      box_y_q      <= '0;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      act_mode_q   <= act_mode_d;
      frame_cnt_q  <= frame_cnt_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.horizSyncOut = hsync_q;
  assign vga.vertSyncOut  = vsync_q;
  assign vga.VGA_R        = r_q;
  assign vga.VGA_G        = g_q;
  assign vga.VGA_B        = b_q;
  assign vga.frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: default 640x480 timing, a small 64x12 raster for frame-level patterns,
// and a tiny 8x4 raster for frame_tick spacing at the 2-clock strobe rate.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   cyc_a = 0;
  int   cyc_b = 0;
  int   cyc_c = 0;
  int   passed = 0;
  int   total = 0;
  int   failed = 0;

  vga_pattern_gen_if #(.COLOR_W(4)) if_a ();
  vga_pattern_gen_if #(.COLOR_W(4)) if_b ();
  vga_pattern_gen_if #(.COLOR_W(4)) if_c ();

  vga_pattern_gen dut_a (
    .CLK100MHZ (clk),
    .reset     (rst_a),
    .vga       (if_a)
  );

  vga_pattern_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_W(4), .STROBE_INC(16'h8000), .BOX_SIZE(8)
  ) dut_b (
    .CLK100MHZ (clk),
    .reset     (rst_b),
    .vga       (if_b)
  );

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_W(4), .STROBE_INC(16'h8000), .BOX_SIZE(32)
  ) dut_c (
    .CLK100MHZ (clk),
    .reset     (rst_c),
    .vga       (if_c)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_a <= rst_a ? 0 : cyc_a + 1;
    cyc_b <= rst_b ? 0 : cyc_b + 1;
    cyc_c <= rst_c ? 0 : cyc_c + 1;
  end

  function automatic logic [31:0] rgb_a();
    return {20'd0, if_a.VGA_R, if_a.VGA_G, if_a.VGA_B};
  endfunction

  function automatic logic [31:0] rgb_b();
    return {20'd0, if_b.VGA_R, if_b.VGA_G, if_b.VGA_B};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Small raster: 80x15 positions per frame, strobe every 2 clocks, one strobe of output latency.
  task automatic goto_b(input int f, input int v, input int h);
    int target;
    target = 2 * (f * 1200 + v * 80 + h + 1);
    while (cyc_b < target) step();
  endtask

  initial begin
    int t_fall;
    if_a.mode = 3'd0;
    if_b.mode = 3'd1;
    if_c.mode = 3'd0;

    // ---------------- default 640x480 timing ----------------
    repeat (3) step();
    check("a_reset_hsync", 32'(if_a.horizSyncOut), 32'd1);
    check("a_reset_vsync", 32'(if_a.vertSyncOut), 32'd1);
    check("a_reset_rgb", rgb_a(), 32'h000);
    check("a_reset_tick", 32'(if_a.frame_tick), 32'd0);
    check("a_reset_hcnt", 32'(dut_a.h_cnt_q), 32'd0);
    rst_a = 1'b0;
    while (cyc_a < 3) step();
    check("a_hcnt_clk3", 32'(dut_a.h_cnt_q), 32'd0);
    step();
    check("a_hcnt_clk4", 32'(dut_a.h_cnt_q), 32'd1);
    while (cyc_a < 8) step();
    check("a_hcnt_clk8", 32'(dut_a.h_cnt_q), 32'd2);
    while ((if_a.horizSyncOut !== 1'b0) && (cyc_a < 4000)) step();
    check("a_hsync_fall_clk", 32'(cyc_a), 32'd2628);
    t_fall = cyc_a;
    while ((if_a.horizSyncOut === 1'b0) && (cyc_a < 8000)) step();
    check("a_hsync_low_clks", 32'(cyc_a - t_fall), 32'd384);
    while ((if_a.horizSyncOut !== 1'b0) && (cyc_a < 8000)) step();
    check("a_line_clks", 32'(cyc_a - t_fall), 32'd3200);
    check("a_vsync_line1", 32'(if_a.vertSyncOut), 32'd1);
    rst_a = 1'b1;

    // ---------------- 64x12 raster: sync, modes, boundaries ----------------
    rst_b = 1'b0;
    goto_b(0, 0, 0);   check("b_f0_black_mode_pending", rgb_b(), 32'h000);
    goto_b(0, 0, 67);  check("b_hsync_h67", 32'(if_b.horizSyncOut), 32'd1);
    goto_b(0, 0, 68);  check("b_hsync_h68", 32'(if_b.horizSyncOut), 32'd0);
    goto_b(0, 0, 75);  check("b_hsync_h75", 32'(if_b.horizSyncOut), 32'd0);
    goto_b(0, 0, 76);  check("b_hsync_h76", 32'(if_b.horizSyncOut), 32'd1);
    goto_b(0, 2, 5);   check("b_f0_black_mid", rgb_b(), 32'h000);
    goto_b(0, 12, 79); check("b_vsync_v12", 32'(if_b.vertSyncOut), 32'd1);
    goto_b(0, 13, 0);  check("b_vsync_v13", 32'(if_b.vertSyncOut), 32'd0);
    goto_b(0, 14, 0);  check("b_vsync_v14", 32'(if_b.vertSyncOut), 32'd1);
    goto_b(0, 14, 78); check("b_tick_before_fb", 32'(if_b.frame_tick), 32'd0);
    goto_b(0, 14, 79); check("b_tick_at_fb", 32'(if_b.frame_tick), 32'd1);
    step();            check("b_tick_one_clk", 32'(if_b.frame_tick), 32'd0);

    goto_b(1, 0, 0);   check("b_f1_red", rgb_b(), 32'hF00);
    goto_b(1, 0, 63);  check("b_f1_red_last_col", rgb_b(), 32'hF00);
    goto_b(1, 0, 64);  check("b_blank_h64", rgb_b(), 32'h000);
    goto_b(1, 0, 79);  check("b_blank_h79", rgb_b(), 32'h000);
    goto_b(1, 5, 0);   if_b.mode = 3'd2;
    goto_b(1, 8, 10);  check("b_red_after_req", rgb_b(), 32'hF00);
    goto_b(1, 11, 63); check("b_red_last_pixel", rgb_b(), 32'hF00);
    goto_b(1, 12, 5);  check("b_blank_v12", rgb_b(), 32'h000);

    goto_b(2, 0, 0);   check("b_bars_white", rgb_b(), 32'hFFF);
    goto_b(2, 0, 8);   check("b_bars_yellow", rgb_b(), 32'hFF0);
    goto_b(2, 0, 16);  check("b_bars_cyan", rgb_b(), 32'h0FF);
    goto_b(2, 0, 56);  check("b_bars_black", rgb_b(), 32'h000);
    goto_b(2, 3, 44);  check("b_bars_red", rgb_b(), 32'hF00);
    goto_b(2, 5, 0);   if_b.mode = 3'd3;

    goto_b(3, 0, 10);  check("b_checker_black", rgb_b(), 32'h000);
    goto_b(3, 0, 40);  check("b_checker_white", rgb_b(), 32'hFFF);
    goto_b(3, 5, 0);   if_b.mode = 3'd6;

    goto_b(4, 3, 4);   check("b_f4_above_box", rgb_b(), 32'h00F);
    goto_b(4, 4, 4);   check("b_f4_box_corner", rgb_b(), 32'h0F0);
    goto_b(4, 4, 12);  check("b_f4_right_of_box", rgb_b(), 32'h00F);
    goto_b(4, 11, 11); check("b_f4_box_bottom_edge", rgb_b(), 32'h0F0);
    goto_b(5, 3, 4);   check("b_f5_left_of_box", rgb_b(), 32'h00F);
    goto_b(5, 3, 5);   check("b_f5_box_corner", rgb_b(), 32'h0F0);
    goto_b(5, 10, 12); check("b_f5_box_far_corner", rgb_b(), 32'h0F0);
    goto_b(5, 11, 8);  check("b_f5_below_box", rgb_b(), 32'h00F);
    if_b.mode = 3'd4;

    goto_b(6, 0, 0);   check("b_grad_0", rgb_b(), 32'h000);
    goto_b(6, 0, 37);  check("b_grad_37", rgb_b(), 32'h999);
    goto_b(6, 0, 63);  check("b_grad_63", rgb_b(), 32'hFFF);
    goto_b(6, 5, 0);   if_b.mode = 3'd5;

    goto_b(7, 0, 0);   check("b_scroll_h0", rgb_b(), 32'hFFF);
    goto_b(7, 0, 1);   check("b_scroll_h1", rgb_b(), 32'hFF0);
    goto_b(7, 0, 56);  check("b_scroll_h56", rgb_b(), 32'h000);
    goto_b(7, 0, 57);  check("b_scroll_h57_wrap", rgb_b(), 32'hFFF);
    goto_b(7, 5, 0);   if_b.mode = 3'd7;

    goto_b(8, 0, 30);  check("b_border_top", rgb_b(), 32'hFFF);
    goto_b(8, 5, 0);   check("b_border_left", rgb_b(), 32'hFFF);
    goto_b(8, 5, 30);  check("b_border_inside", rgb_b(), 32'h000);
    goto_b(8, 5, 63);  check("b_border_right", rgb_b(), 32'hFFF);
    goto_b(8, 10, 62); check("b_border_inside2", rgb_b(), 32'h000);
    goto_b(8, 11, 30); check("b_border_bottom", rgb_b(), 32'hFFF);

    goto_b(9, 0, 30);  check("b_pre_reset_white", rgb_b(), 32'hFFF);
    rst_b = 1'b1;
    step();
    check("b_midreset_hcnt", 32'(dut_b.h_cnt_q), 32'd0);
    check("b_midreset_vcnt", 32'(dut_b.v_cnt_q), 32'd0);
    check("b_midreset_rgb", rgb_b(), 32'h000);
    check("b_midreset_hsync", 32'(if_b.horizSyncOut), 32'd1);
    check("b_midreset_vsync", 32'(if_b.vertSyncOut), 32'd1);
    step();
    rst_b = 1'b0;
    goto_b(0, 0, 0);   check("b_restart_mode0", rgb_b(), 32'h000);
    goto_b(0, 0, 67);  check("b_restart_hsync_h67", 32'(if_b.horizSyncOut), 32'd1);
    goto_b(0, 0, 68);  check("b_restart_hsync_h68", 32'(if_b.horizSyncOut), 32'd0);
    rst_b = 1'b1;

    // ---------------- 8x4 raster at strobe every 2 clocks ----------------
    rst_c = 1'b0;
    while (cyc_c < 1) step();
    check("c_hcnt_clk1", 32'(dut_c.h_cnt_q), 32'd0);
    step();
    check("c_hcnt_clk2", 32'(dut_c.h_cnt_q), 32'd1);
    while ((if_c.frame_tick !== 1'b1) && (cyc_c < 1000)) step();
    check("c_first_tick_clk", 32'(cyc_c), 32'd168);
    step();
    check("c_tick_width", 32'(if_c.frame_tick), 32'd0);
    while ((if_c.frame_tick !== 1'b1) && (cyc_c < 1000)) step();
    check("c_second_tick_clk", 32'(cyc_c), 32'd336);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
